// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//
// Generic pipeline stage register for the 5-stage MIPS core. One instance sits
// between each pair of stages (IF/ID, ID/EX, EX/MEM, MEM/WB) and carries the
// PC, a packed payload, an exception code and the branch-delay flag under a
// valid/ready handshake.
//
// With SKID=1 a second (skid) entry lets in_ready come straight from a flop,
// so the upstream ready path never sees out_ready combinationally. With
// SKID=0 the stage is a single register and in_ready is combinational.
//
// Ports:
//   clk         in   rising-edge clock
//   reset       in   synchronous, active-high
//   in_valid    in   upstream entry valid
//   in_ready    out  stage can accept this cycle
//   in_pc       in   upstream PC            [PC_W]
//   in_data     in   upstream payload       [DW]
//   in_exc      in   upstream exc code      [EXC_W], 0 = none
//   in_bd       in   upstream branch-delay flag
//   flush       in   kill all held entries (exception / eret)
//   out_valid   out  downstream entry valid
//   out_ready   in   downstream accepts
//   out_pc      out  held PC (tracks through bubbles, survives flush)
//   out_data    out  held payload, 0 when out_valid=0
//   out_exc     out  held exc code, 0 when out_valid=0
//   out_bd      out  held branch-delay flag (survives flush)
//   bubble_cnt  out  saturating count of cycles with out_ready=1, out_valid=0
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int DW    = 64,
    parameter int PC_W  = 32,
    parameter int EXC_W = 5,
    parameter int SKID  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PC_W-1:0]  in_pc,
    input  logic [DW-1:0]    in_data,
    input  logic [EXC_W-1:0] in_exc,
    input  logic             in_bd,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PC_W-1:0]  out_pc,
    output logic [DW-1:0]    out_data,
    output logic [EXC_W-1:0] out_exc,
    output logic             out_bd,
    output logic [15:0]      bubble_cnt
);

    // Main entry: this is what the downstream stage sees.
    logic             r_m_vld;
    logic [PC_W-1:0]  r_m_pc;
    logic [DW-1:0]    r_m_data;
    logic [EXC_W-1:0] r_m_exc;
    logic             r_m_bd;

    // Skid entry: only ever occupied while main is valid and stalled.
    logic             r_s_vld;
    logic [PC_W-1:0]  r_s_pc;
    logic [DW-1:0]    r_s_data;
    logic [EXC_W-1:0] r_s_exc;
    logic             r_s_bd;

    logic [15:0]      r_bubble_cnt;

    logic w_in_ready;
    logic w_accept;
    logic w_drain;
    logic w_main_free;

    always_comb begin
        // Skid build: ready is the inverse of a flop, so it is registered.
        // Single-register build: ready whenever main is empty or leaving.
        if (SKID != 0) begin
            w_in_ready = ~r_s_vld;
        end else begin
            w_in_ready = out_ready | ~r_m_vld;
        end
        // Anything offered during a flush is dropped even if ready is high.
        w_accept    = in_valid & w_in_ready & ~flush;
        w_drain     = r_m_vld & out_ready;
        w_main_free = ~r_m_vld | w_drain;
    end

    // Main register. Data/exc are forced to zero whenever the entry is
    // invalid, which is what keeps out_data/out_exc at 0 during bubbles.
    // PC/BD are deliberately left alone on flush so EPC can be formed.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_m_vld  <= 1'b0;
            r_m_pc   <= '0;
            r_m_data <= '0;
            r_m_exc  <= '0;
            r_m_bd   <= 1'b0;
        end else if (flush) begin
            r_m_vld  <= 1'b0;
            r_m_data <= '0;
            r_m_exc  <= '0;
        end else if (w_main_free) begin
            if (r_s_vld) begin
                r_m_vld  <= 1'b1;
                r_m_pc   <= r_s_pc;
                r_m_data <= r_s_data;
                r_m_exc  <= r_s_exc;
                r_m_bd   <= r_s_bd;
            end else if (w_accept) begin
                r_m_vld  <= 1'b1;
                r_m_pc   <= in_pc;
                r_m_data <= in_data;
                r_m_exc  <= in_exc;
                r_m_bd   <= in_bd;
            end else begin
                // Bubble: PC/BD follow upstream so the slot still has an address.
                r_m_vld  <= 1'b0;
                r_m_pc   <= in_pc;
                r_m_data <= '0;
                r_m_exc  <= '0;
                r_m_bd   <= in_bd;
            end
        end
    end

    // Skid valid. When main frees up the skid entry (if any) moves into it,
    // so the skid always empties on that cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s_vld <= 1'b0;
        end else if (flush) begin
            r_s_vld <= 1'b0;
        end else if (w_main_free) begin
            r_s_vld <= 1'b0;
        end else if ((SKID != 0) && w_accept) begin
            r_s_vld <= 1'b1;
        end
    end

    // Skid payload needs no reset; it is only read while r_s_vld is set.
    always_ff @(posedge clk) begin
        if (w_accept && !w_main_free) begin
            r_s_pc   <= in_pc;
            r_s_data <= in_data;
            r_s_exc  <= in_exc;
            r_s_bd   <= in_bd;
        end
    end

    // Bubble counter: only reset clears it, flush does not.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bubble_cnt <= '0;
        end else if (out_ready && !r_m_vld && (r_bubble_cnt != 16'hFFFF)) begin
            r_bubble_cnt <= r_bubble_cnt + 16'd1;
        end
    end

    assign in_ready   = w_in_ready;
    assign out_valid  = r_m_vld;
    assign out_pc     = r_m_pc;
    assign out_data   = r_m_data;
    assign out_exc    = r_m_exc;
    assign out_bd     = r_m_bd;
    assign bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
//
// Two instances: u_dut (SKID=1) is driven by directed scenarios followed by
// random traffic and compared every cycle against a queue-based model;
// u_dut0 (SKID=0) is exercised in a parallel process for the combinational
// ready path and bubble counter saturation.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

    localparam int DW    = 64;
    localparam int PC_W  = 32;
    localparam int EXC_W = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- SKID=1 instance ----------------
    logic             t_rst, t_fl, t_iv, t_bd, t_ordy;
    logic [PC_W-1:0]  t_pc;
    logic [DW-1:0]    t_data;
    logic [EXC_W-1:0] t_exc;
    logic             in_ready, out_valid, out_bd;
    logic [PC_W-1:0]  out_pc;
    logic [DW-1:0]    out_data;
    logic [EXC_W-1:0] out_exc;
    logic [15:0]      bubble_cnt;

    pipe_stage_reg #(.DW(DW), .PC_W(PC_W), .EXC_W(EXC_W), .SKID(1)) u_dut (
        .clk(clk), .reset(t_rst), .in_valid(t_iv), .in_ready(in_ready),
        .in_pc(t_pc), .in_data(t_data), .in_exc(t_exc), .in_bd(t_bd),
        .flush(t_fl), .out_valid(out_valid), .out_ready(t_ordy),
        .out_pc(out_pc), .out_data(out_data), .out_exc(out_exc),
        .out_bd(out_bd), .bubble_cnt(bubble_cnt)
    );

    // ---------------- SKID=0 instance ----------------
    logic             r0, fl0, iv0, bd0, ordy0;
    logic [PC_W-1:0]  pc0;
    logic [DW-1:0]    d0;
    logic [EXC_W-1:0] e0;
    logic             in_ready0, out_valid0, out_bd0;
    logic [PC_W-1:0]  out_pc0;
    logic [DW-1:0]    out_data0;
    logic [EXC_W-1:0] out_exc0;
    logic [15:0]      bubble_cnt0;
    logic             done0 = 1'b0;

    pipe_stage_reg #(.DW(DW), .PC_W(PC_W), .EXC_W(EXC_W), .SKID(0)) u_dut0 (
        .clk(clk), .reset(r0), .in_valid(iv0), .in_ready(in_ready0),
        .in_pc(pc0), .in_data(d0), .in_exc(e0), .in_bd(bd0),
        .flush(fl0), .out_valid(out_valid0), .out_ready(ordy0),
        .out_pc(out_pc0), .out_data(out_data0), .out_exc(out_exc0),
        .out_bd(out_bd0), .bubble_cnt(bubble_cnt0)
    );

    // ---------------- checking ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model (SKID=1) ----------------
    // Held entries form a FIFO of depth 2; the front is what is presented.
    typedef struct packed {
        logic [PC_W-1:0]  pc;
        logic [DW-1:0]    data;
        logic [EXC_W-1:0] exc;
        logic             bd;
    } ent_t;

    ent_t            q[$];
    logic [PC_W-1:0] m_pc;   // presented PC when nothing is held
    logic            m_bd;
    int              m_cnt;

    task automatic model_step();
        ent_t ne;
        bit   can_take;
        if (t_rst) begin
            q.delete();
            m_pc  = '0;
            m_bd  = 1'b0;
            m_cnt = 0;
        end else begin
            if (t_ordy && q.size() == 0 && m_cnt < 65535) m_cnt++;
            if (t_fl) begin
                if (q.size() > 0) begin
                    m_pc = q[0].pc;
                    m_bd = q[0].bd;
                end
                q.delete();
            end else begin
                can_take = (q.size() < 2);
                if (t_ordy && q.size() > 0) void'(q.pop_front());
                if (t_iv && can_take) begin
                    ne.pc   = t_pc;
                    ne.data = t_data;
                    ne.exc  = t_exc;
                    ne.bd   = t_bd;
                    q.push_back(ne);
                end
                if (q.size() == 0) begin
                    m_pc = t_pc;
                    m_bd = t_bd;
                end
            end
        end
    endtask

    task automatic compare_all();
        bit nonempty;
        nonempty = (q.size() > 0);
        check("in_ready",   in_ready,   (q.size() < 2));
        check("out_valid",  out_valid,  nonempty);
        check("out_pc",     out_pc,     nonempty ? q[0].pc   : m_pc);
        check("out_bd",     out_bd,     nonempty ? q[0].bd   : m_bd);
        check("out_data",   out_data,   nonempty ? q[0].data : 64'd0);
        check("out_exc",    out_exc,    nonempty ? q[0].exc  : 5'd0);
        check("bubble_cnt", bubble_cnt, m_cnt);
    endtask

    // Apply one cycle of inputs, advance the model across the edge, compare.
    task automatic drive(input logic rst, input logic fl, input logic iv,
                         input logic [PC_W-1:0] pc, input logic [EXC_W-1:0] exc,
                         input logic bd, input logic ordy);
        t_rst  = rst;
        t_fl   = fl;
        t_iv   = iv;
        t_pc   = pc;
        t_data = {$urandom, $urandom};
        t_exc  = exc;
        t_bd   = bd;
        t_ordy = ordy;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    // ---------------- SKID=1 stimulus ----------------
    initial begin
        int guard;
        q.delete();
        m_pc = '0; m_bd = 1'b0; m_cnt = 0;

        // Reset
        drive(1, 0, 0, 32'h0, 0, 0, 1);
        drive(1, 0, 0, 32'h0, 0, 0, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_pc", out_pc, 0);
        check("rst_bubble", bubble_cnt, 0);
        check("rst_in_ready", in_ready, 1);

        // Stream 0x3000/0x3004/0x3008
        drive(0, 0, 1, 32'h3000, 0, 0, 0);
        check("stream0_pc", out_pc, 32'h3000);
        check("stream0_vld", out_valid, 1);
        drive(0, 0, 1, 32'h3004, 0, 0, 1);
        check("stream1_pc", out_pc, 32'h3004);
        check("stream1_rdy", in_ready, 1);
        drive(0, 0, 1, 32'h3008, 0, 0, 1);
        check("stream2_pc", out_pc, 32'h3008);
        check("stream_bubble", bubble_cnt, 0);

        // Bubble with PC/BD tracking
        drive(0, 0, 0, 32'h3010, 0, 1, 1);
        check("bubble_vld", out_valid, 0);
        check("bubble_pc", out_pc, 32'h3010);
        check("bubble_bd", out_bd, 1);
        check("bubble_data", out_data, 0);
        drive(0, 0, 0, 32'h3010, 0, 1, 1);
        check("bubble_cnt1", bubble_cnt, 1);

        // Fill to TWO under backpressure, then flush
        drive(0, 0, 1, 32'h3000, 5'h0A, 0, 0);
        drive(0, 0, 1, 32'h3004, 5'h00, 0, 0);
        check("bp_in_ready", in_ready, 0);
        check("bp_pc", out_pc, 32'h3000);
        check("bp_exc", out_exc, 5'h0A);
        drive(0, 0, 1, 32'h3008, 0, 0, 0);
        check("bp_hold_pc", out_pc, 32'h3000);
        drive(0, 1, 1, 32'h3008, 0, 0, 0);
        check("flush_vld", out_valid, 0);
        check("flush_exc", out_exc, 0);
        check("flush_pc", out_pc, 32'h3000);
        check("flush_rdy", in_ready, 1);
        drive(0, 0, 0, 32'h3020, 0, 0, 0);
        check("flush_drop", out_valid, 0);

        // Fill again, release in order
        drive(0, 0, 1, 32'h3000, 0, 0, 0);
        drive(0, 0, 1, 32'h3004, 0, 0, 0);
        drive(0, 0, 0, 32'h3030, 0, 0, 1);
        check("rel0_pc", out_pc, 32'h3004);
        check("rel0_vld", out_valid, 1);
        drive(0, 0, 0, 32'h3030, 0, 0, 1);
        check("rel1_vld", out_valid, 0);

        // Reset + flush while full
        drive(0, 0, 1, 32'h3000, 5'h0A, 1, 0);
        drive(0, 0, 1, 32'h3004, 0, 1, 0);
        drive(1, 1, 1, 32'h3008, 0, 1, 1);
        check("rf_pc", out_pc, 0);
        check("rf_bd", out_bd, 0);
        check("rf_vld", out_valid, 0);
        check("rf_bubble", bubble_cnt, 0);

        // Random traffic
        for (int i = 0; i < 2500; i++) begin
            logic [EXC_W-1:0] ex;
            ex = ($urandom_range(0, 3) == 0) ? EXC_W'($urandom) : '0;
            drive(($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 3) != 0),
                  {$urandom} & 32'hFFFF_FFFC,
                  ex,
                  1'($urandom),
                  ($urandom_range(0, 2) != 0));
        end

        guard = 0;
        while (!done0 && guard < 70000) begin
            @(posedge clk);
            guard++;
        end
        check("skid0_done", done0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // ---------------- SKID=0 stimulus ----------------
    initial begin
        r0 = 1; fl0 = 0; iv0 = 0; bd0 = 0; ordy0 = 0;
        pc0 = '0; d0 = '0; e0 = '0;
        repeat (2) @(posedge clk);
        #1;
        r0 = 0; iv0 = 1; pc0 = 32'h4000; d0 = 64'h0000_00A5; ordy0 = 0;
        @(posedge clk);
        #1;
        check("s0_vld", out_valid0, 1);
        check("s0_pc", out_pc0, 32'h4000);
        check("s0_data", out_data0, 64'hA5);
        check("s0_stall_rdy", in_ready0, 0);
        iv0 = 0; ordy0 = 1;
        #1;
        check("s0_comb_rdy", in_ready0, 1);
        @(posedge clk);
        #1;
        check("s0_drain_vld", out_valid0, 0);
        check("s0_drain_data", out_data0, 0);
        check("s0_bubble0", bubble_cnt0, 0);
        repeat (100) @(posedge clk);
        #1;
        check("s0_bubble100", bubble_cnt0, 100);
        repeat (66000) @(posedge clk);
        #1;
        check("s0_bubble_sat", bubble_cnt0, 16'hFFFF);
        done0 = 1'b1;
    end

endmodule
